// File: rtl/hilo_acc.sv
// hilo_acc: HI/LO special-register pair with a two-stage multiply-accumulate.
// Optional HILO_BYPASS_EN forwards direct HI/LO writes to hi_o/lo_o.
//
// Ports:
//   clk      clock; all state changes on the falling edge
//   rst      asynchronous active-high reset
//   valid_i  request present
//   op_i     000 NOP, 001 MTHI, 010 MTLO, 011 WBOTH,
//            100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
//   hi_i     HI write data
//   lo_i     LO write data
//   a_i      MAC multiplicand
//   b_i      MAC multiplier
//   ready_o  request can be accepted this cycle
//   busy_o   MAC accumulate stage occupied
//   hi_o     HI value
//   lo_o     LO value
module hilo_acc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [W2-1:0]    prod_q;
  logic             sub_q;

  logic          accept;
  logic          wr_hi;
  logic          wr_lo;
  logic          mac_go;
  logic [W2-1:0] prod_d;
  logic [W2-1:0] acc_q;
  logic [W2-1:0] acc_d;

  assign busy_o  = (state_q == ACC);
  assign ready_o = !busy_o;
  assign accept  = valid_i && ready_o;

  always_comb begin
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    mac_go = 1'b0;
    if (accept) begin
      unique case (op_i)
        3'b001:  wr_hi  = 1'b1;
        3'b010:  wr_lo  = 1'b1;
        3'b011: begin
          wr_hi = 1'b1;
          wr_lo = 1'b1;
        end
        3'b100,
        3'b101,
        3'b110,
        3'b111:  mac_go = 1'b1;
        default: ;
      endcase
    end
  end

  // Extending to 2*WIDTH before multiplying gives the exact
  // signed or unsigned product in the low 2*WIDTH bits.
  always_comb begin
    prod_d = '0;
    if (op_i[0]) begin
      prod_d = {{WIDTH{1'b0}}, a_i}
             * {{WIDTH{1'b0}}, b_i};
    end else begin
      prod_d = {{WIDTH{a_i[WIDTH-1]}}, a_i}
             * {{WIDTH{b_i[WIDTH-1]}}, b_i};
    end
  end

  assign acc_q = {hi_q, lo_q};

  always_comb begin
    acc_d = acc_q + prod_q;
    if (sub_q) begin
      acc_d = acc_q - prod_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mac_go) begin
          state_d = ACC;
        end
      end
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mac_go) begin
        prod_q <= prod_d;
        sub_q  <= op_i[1];
      end
      // Direct writes are blocked while ACC, so no overlap here.
      if (state_q == ACC) begin
        {hi_q, lo_q} <= acc_d;
      end else begin
        if (wr_hi) begin
          hi_q <= hi_i;
        end
        if (wr_lo) begin
          lo_q <= lo_i;
        end
      end
    end
  end

`ifdef HILO_BYPASS_EN
  assign hi_o = wr_hi ? hi_i : hi_q;
  assign lo_o = wr_lo ? lo_i : lo_q;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_acc.sv
// tb_hilo_acc: directed self-checking bench for hilo_acc.
// Inputs change and outputs are sampled 1ns after falling edges.
module tb_hilo_acc;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        ready_o;
  logic        busy_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  localparam logic [2:0] NOP   = 3'b000;
  localparam logic [2:0] MTHI  = 3'b001;
  localparam logic [2:0] MTLO  = 3'b010;
  localparam logic [2:0] WBOTH = 3'b011;
  localparam logic [2:0] MADD  = 3'b100;
  localparam logic [2:0] MADDU = 3'b101;
  localparam logic [2:0] MSUB  = 3'b110;
  localparam logic [2:0] MSUBU = 3'b111;

  hilo_acc #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .op_i    (op_i),
    .hi_i    (hi_i),
    .lo_i    (lo_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] op,
                         input logic [31:0] h,
                         input logic [31:0] l,
                         input logic [31:0] a,
                         input logic [31:0] b);
    valid_i = 1'b1;
    op_i    = op;
    hi_i    = h;
    lo_i    = l;
    a_i     = a;
    b_i     = b;
  endtask

  task automatic edge1();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    op_i    = NOP;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] h,
                       input logic [31:0] l,
                       input logic [31:0] a,
                       input logic [31:0] b);
    set_req(op, h, l, a, b);
    edge1();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    hi_i = '0;
    lo_i = '0;
    a_i  = '0;
    b_i  = '0;
    #2;
    chk("rst0_hi", hi_o, 32'h0);
    chk("rst0_lo", lo_o, 32'h0);
    chk("rst0_busy", {31'b0, busy_o}, 32'h0);
    chk("rst0_ready", {31'b0, ready_o}, 32'h1);
    #1 rst = 1'b0;
    edge1();

    issue(WBOTH, 32'h12345678, 32'h9ABCDEF0, 0, 0);
    chk("wboth_hi", hi_o, 32'h12345678);
    chk("wboth_lo", lo_o, 32'h9ABCDEF0);
    issue(MTHI, 32'hFFFFFFFF, 32'h1111, 0, 0);
    chk("mthi_hi", hi_o, 32'hFFFFFFFF);
    chk("mthi_lo", lo_o, 32'h9ABCDEF0);
    issue(MTLO, 32'h2222, 32'h0BADF00D, 0, 0);
    chk("mtlo_hi", hi_o, 32'hFFFFFFFF);
    chk("mtlo_lo", lo_o, 32'h0BADF00D);
    issue(NOP, 32'h3333, 32'h4444, 0, 0);
    chk("nop_hi", hi_o, 32'hFFFFFFFF);
    chk("nop_lo", lo_o, 32'h0BADF00D);

    #2 rst = 1'b1;
    #1;
    chk("arst_hi", hi_o, 32'h0);
    chk("arst_lo", lo_o, 32'h0);
    chk("arst_busy", {31'b0, busy_o}, 32'h0);
    chk("arst_ready", {31'b0, ready_o}, 32'h1);
    #1 rst = 1'b0;
    edge1();

    issue(WBOTH, 32'h0, 32'hFFFFFFFF, 0, 0);
    issue(MADDU, 0, 0, 32'h1, 32'h1);
    chk("maddu_ready", {31'b0, ready_o}, 32'h0);
    chk("maddu_busy", {31'b0, busy_o}, 32'h1);
    chk("maddu_hold_hi", hi_o, 32'h0);
    chk("maddu_hold_lo", lo_o, 32'hFFFFFFFF);
    edge1();
    chk("maddu_ready2", {31'b0, ready_o}, 32'h1);
    chk("maddu_busy2", {31'b0, busy_o}, 32'h0);
    chk("maddu_hi", hi_o, 32'h1);
    chk("maddu_lo", lo_o, 32'h0);

    issue(WBOTH, 32'h0, 32'h0, 0, 0);
    issue(MSUB, 0, 0, 32'd2, 32'd3);
    edge1();
    chk("msub_hi", hi_o, 32'hFFFFFFFF);
    chk("msub_lo", lo_o, 32'hFFFFFFFA);
    issue(MADD, 0, 0, 32'hFFFFFFFF, 32'd6);
    edge1();
    chk("madd_neg_hi", hi_o, 32'hFFFFFFFF);
    chk("madd_neg_lo", lo_o, 32'hFFFFFFF4);

    set_req(MADD, 0, 0, 32'd2, 32'd3);
    edge1();
    set_req(MTLO, 32'h0, 32'h55, 0, 0);
    chk("held_busy", {31'b0, busy_o}, 32'h1);
    chk("held_lo0", lo_o, 32'hFFFFFFF4);
    edge1();
    chk("held_busy2", {31'b0, busy_o}, 32'h0);
    chk("held_hi1", hi_o, 32'hFFFFFFFF);
`ifdef HILO_BYPASS_EN
    chk("held_lo1", lo_o, 32'h55);
`else
    chk("held_lo1", lo_o, 32'hFFFFFFFA);
`endif
    edge1();
    idle();
    chk("held_hi2", hi_o, 32'hFFFFFFFF);
    chk("held_lo2", lo_o, 32'h55);

    issue(MADD, 0, 0, 32'd5, 32'd7);
    chk("midrst_busy0", {31'b0, busy_o}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_hi", hi_o, 32'h0);
    chk("midrst_lo", lo_o, 32'h0);
    chk("midrst_busy", {31'b0, busy_o}, 32'h0);
    #1 rst = 1'b0;
    edge1();
    chk("midrst_hi2", hi_o, 32'h0);
    chk("midrst_lo2", lo_o, 32'h0);
    chk("midrst_busy2", {31'b0, busy_o}, 32'h0);

    rst = 1'b1;
    set_req(WBOTH, 32'hAAAA, 32'hBBBB, 0, 0);
    edge1();
    idle();
    rst = 1'b0;
    chk("rstwin_hi", hi_o, 32'h0);
    chk("rstwin_lo", lo_o, 32'h0);

    issue(MADDU, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    edge1();
    chk("maddu_big_hi", hi_o, 32'hFFFFFFFE);
    chk("maddu_big_lo", lo_o, 32'h00000001);
    issue(MSUBU, 0, 0, 32'd2, 32'd3);
    edge1();
    chk("msubu_hi", hi_o, 32'hFFFFFFFD);
    chk("msubu_lo", lo_o, 32'hFFFFFFFB);

    issue(WBOTH, 32'h0, 32'h0, 0, 0);
    issue(MADD, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    edge1();
    chk("madd_m1sq_hi", hi_o, 32'h0);
    chk("madd_m1sq_lo", lo_o, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
